// File: rtl/npc_sched_if.sv
// Purpose: bundles the next-PC scheduler's control inputs and PC-facing outputs.
// Latency: none. This is wiring only.
// Backpressure: none. Stalls are carried explicitly by hz_stall, halt_req and n_stall.
// Ports: master drives boot_go/hz_stall/br_*/jmp_*/halt_req/resume and observes
//        npc/npc_enn/n_stall/flush/state/redir_cnt; slave is the scheduler side.
interface npc_sched_if #(
  parameter int AW = 25,
  parameter int CW = 16
);
  logic          boot_go;
  logic          hz_stall;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          jmp_valid;
  logic [AW-1:0] jmp_target;
  logic          halt_req;
  logic          resume;
  logic [AW-1:0] npc;
  logic          npc_enn;
  logic          n_stall;
  logic          flush;
  logic [1:0]    state;
  logic [CW-1:0] redir_cnt;

  modport master (
    output boot_go, hz_stall, br_taken, br_target, jmp_valid, jmp_target,
           halt_req, resume,
    input  npc, npc_enn, n_stall, flush, state, redir_cnt
  );

  modport slave (
    input  boot_go, hz_stall, br_taken, br_target, jmp_valid, jmp_target,
           halt_req, resume,
    output npc, npc_enn, n_stall, flush, state, redir_cnt
  );
endinterface

// File: rtl/npc_sched.sv
// Purpose: next-PC scheduler. It arbitrates branch/jump/boot redirects, merges stall and halt, and holds a frozen-PC redirect.
// Latency: npc/npc_enn/n_stall/flush are combinational from the state and inputs. A redirect loads the PC at the next edge.
// Backpressure: hz_stall/halt_req drop n_stall. A redirect that arrives while frozen is parked in a one-entry pend slot.
// Ports: i_clk, i_rst (sync, active-high), io_sch (npc_sched_if.slave).
module npc_sched #(
  parameter int            AW        = 25,
  parameter int            CW        = 16,
  parameter logic [AW-1:0] BOOT_ADDR = '0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  npc_sched_if.slave  io_sch
);
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic          SRC_BR  = 1'b0;
  localparam logic          SRC_JMP = 1'b1;
  localparam logic [AW-1:0] ONE     = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        r_state;
  logic          r_pend_v;
  logic          r_pend_src;
  logic [AW-1:0] r_pend_tgt;
  logic [CW-1:0] r_redir_cnt;

  state_t        w_nxt_state;
  logic [AW-1:0] w_npc;
  logic          w_npc_enn;
  logic          w_n_stall;
  logic          w_flush;
  logic          w_cnt_inc;
  logic          w_pend_ld;
  logic          w_pend_clr;
  logic          w_pend_src_d;
  logic [AW-1:0] w_pend_tgt_d;

  // Branch wins over jump because it belongs to the older instruction.
  logic          w_sel_v;
  logic          w_sel_src;
  logic [AW-1:0] w_sel_tgt;
  // While pending, a younger jump may be replaced by a branch. A pending branch is never replaced.
  logic          w_br_ovr;

  assign w_sel_v   = io_sch.br_taken | io_sch.jmp_valid;
  assign w_sel_src = io_sch.br_taken ? SRC_BR : SRC_JMP;
  assign w_sel_tgt = io_sch.br_taken ? io_sch.br_target : io_sch.jmp_target;
  assign w_br_ovr  = io_sch.br_taken && (r_pend_src == SRC_JMP);

  // The PC adds 1 to whatever it loads, so every redirect drives target-1.
  always_comb begin
    w_nxt_state  = r_state;
    w_npc        = '0;
    w_npc_enn    = 1'b0;
    w_n_stall    = 1'b0;
    w_flush      = 1'b0;
    w_cnt_inc    = 1'b0;
    w_pend_ld    = 1'b0;
    w_pend_clr   = 1'b0;
    w_pend_src_d = r_pend_src;
    w_pend_tgt_d = r_pend_tgt;
    if (!i_rst) begin
      unique case (r_state)
        ST_BOOT: begin
          if (io_sch.boot_go) begin
            w_n_stall   = 1'b1;
            w_npc_enn   = 1'b1;
            w_npc       = BOOT_ADDR - ONE;
            w_flush     = 1'b1;
            w_nxt_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (io_sch.halt_req || io_sch.hz_stall) begin
            // Frozen: park any redirect. A stall goes to PEND only if a redirect was parked.
            w_pend_ld    = w_sel_v;
            w_pend_src_d = w_sel_src;
            w_pend_tgt_d = w_sel_tgt;
            if (io_sch.halt_req)
              w_nxt_state = ST_HALT;
            else if (w_sel_v)
              w_nxt_state = ST_PEND;
          end else if (w_sel_v) begin
            w_n_stall = 1'b1;
            w_npc_enn = 1'b1;
            w_npc     = w_sel_tgt - ONE;
            w_flush   = 1'b1;
            w_cnt_inc = 1'b1;
          end else begin
            w_n_stall = 1'b1;
          end
        end
        ST_PEND: begin
          if (io_sch.halt_req || io_sch.hz_stall) begin
            w_pend_ld    = w_br_ovr;
            w_pend_src_d = SRC_BR;
            w_pend_tgt_d = io_sch.br_target;
            if (io_sch.halt_req)
              w_nxt_state = ST_HALT;
          end else begin
            w_n_stall   = 1'b1;
            w_npc_enn   = 1'b1;
            w_npc       = (w_br_ovr ? io_sch.br_target : r_pend_tgt) - ONE;
            w_flush     = 1'b1;
            w_cnt_inc   = 1'b1;
            w_pend_clr  = 1'b1;
            w_nxt_state = ST_RUN;
          end
        end
        ST_HALT: begin
          if (io_sch.resume && !io_sch.halt_req)
            w_nxt_state = r_pend_v ? ST_PEND : ST_RUN;
        end
        default: w_nxt_state = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_BOOT;
      r_pend_v    <= 1'b0;
      r_pend_src  <= SRC_BR;
      r_pend_tgt  <= '0;
      r_redir_cnt <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_pend_ld) begin
        r_pend_v   <= 1'b1;
        r_pend_src <= w_pend_src_d;
        r_pend_tgt <= w_pend_tgt_d;
      end else if (w_pend_clr) begin
        r_pend_v <= 1'b0;
      end
      if (w_cnt_inc && (r_redir_cnt != CNT_MAX))
        r_redir_cnt <= r_redir_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign io_sch.npc       = w_npc;
  assign io_sch.npc_enn   = w_npc_enn;
  assign io_sch.n_stall   = w_n_stall;
  assign io_sch.flush     = w_flush;
  assign io_sch.state     = r_state;
  assign io_sch.redir_cnt = r_redir_cnt;
endmodule

// File: tb/tb_npc_sched.sv
// Purpose: directed self-checking bench for npc_sched (AW=25, CW=2, BOOT_ADDR=0).
// Latency: inputs are driven at the negedge, combinational outputs are checked 2ns later, and registered state is checked at the following negedge.
// Backpressure: the sequence covers stall, halt/resume and the pend slot.
module tb_npc_sched;
  localparam int AW = 25;
  localparam int CW = 2;

  logic i_clk;
  logic i_rst;
  int   errors;
  int   checks;

  npc_sched_if #(.AW(AW), .CW(CW)) sch ();

  npc_sched #(.AW(AW), .CW(CW), .BOOT_ADDR('0)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .io_sch (sch.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    sch.boot_go    = 1'b0;
    sch.hz_stall   = 1'b0;
    sch.br_taken   = 1'b0;
    sch.br_target  = '0;
    sch.jmp_valid  = 1'b0;
    sch.jmp_target = '0;
    sch.halt_req   = 1'b0;
    sch.resume     = 1'b0;
  endtask

  // Advance to the next negedge, then clear the inputs for the next step.
  task automatic tick();
    @(negedge i_clk);
    idle_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    i_rst = 1'b1;

    // Reset: outputs held low, even with boot_go asserted.
    @(negedge i_clk);
    sch.boot_go = 1'b1;
    #2;
    chk("rst_n_stall", 32'(sch.n_stall), 32'd0);
    chk("rst_npc_enn", 32'(sch.npc_enn), 32'd0);
    chk("rst_flush",   32'(sch.flush),   32'd0);
    chk("rst_npc",     32'(sch.npc),     32'd0);
    tick();
    i_rst = 1'b0;
    #2;
    chk("rst_state", 32'(sch.state),     32'd0);
    chk("rst_cnt",   32'(sch.redir_cnt), 32'd0);
    chk("boot_idle_n_stall", 32'(sch.n_stall), 32'd0);
    tick();
    chk("boot_hold_state", 32'(sch.state), 32'd0);

    // 1: boot_go with an ignored branch.
    sch.boot_go = 1'b1; sch.br_taken = 1'b1; sch.br_target = 25'h55;
    #2;
    chk("boot_npc",     32'(sch.npc),     32'h1FFFFFF);
    chk("boot_npc_enn", 32'(sch.npc_enn), 32'd1);
    chk("boot_flush",   32'(sch.flush),   32'd1);
    chk("boot_n_stall", 32'(sch.n_stall), 32'd1);
    tick(); #2;
    chk("run_state",   32'(sch.state),     32'd1);
    chk("run_n_stall", 32'(sch.n_stall),   32'd1);
    chk("run_npc_enn", 32'(sch.npc_enn),   32'd0);
    chk("run_flush",   32'(sch.flush),     32'd0);
    chk("boot_cnt",    32'(sch.redir_cnt), 32'd0);

    // 2: branch beats jump in the same cycle.
    sch.br_taken = 1'b1; sch.br_target = 25'h100;
    sch.jmp_valid = 1'b1; sch.jmp_target = 25'h200;
    #2;
    chk("br_npc",     32'(sch.npc),     32'h0FF);
    chk("br_npc_enn", 32'(sch.npc_enn), 32'd1);
    chk("br_flush",   32'(sch.flush),   32'd1);
    tick(); #2;
    chk("br_cnt",   32'(sch.redir_cnt), 32'd1);
    chk("br_state", 32'(sch.state),     32'd1);

    // 3: a three-cycle stall. The jump is parked and then replaced by a branch.
    sch.hz_stall = 1'b1; sch.jmp_valid = 1'b1; sch.jmp_target = 25'h40;
    #2;
    chk("st1_n_stall", 32'(sch.n_stall), 32'd0);
    chk("st1_npc_enn", 32'(sch.npc_enn), 32'd0);
    chk("st1_flush",   32'(sch.flush),   32'd0);
    tick();
    sch.hz_stall = 1'b1; sch.br_taken = 1'b1; sch.br_target = 25'h80;
    #2;
    chk("st2_state",   32'(sch.state),   32'd2);
    chk("st2_n_stall", 32'(sch.n_stall), 32'd0);
    tick();
    sch.hz_stall = 1'b1;
    #2;
    chk("st3_n_stall", 32'(sch.n_stall), 32'd0);
    chk("st3_state",   32'(sch.state),   32'd2);
    tick(); #2;
    chk("pend_npc",     32'(sch.npc),     32'h07F);
    chk("pend_npc_enn", 32'(sch.npc_enn), 32'd1);
    chk("pend_flush",   32'(sch.flush),   32'd1);
    tick(); #2;
    chk("pend_once_state", 32'(sch.state),     32'd1);
    chk("pend_once_enn",   32'(sch.npc_enn),   32'd0);
    chk("pend_cnt",        32'(sch.redir_cnt), 32'd2);

    // 4: halt with a parked branch, then halt+resume (stays), then resume.
    sch.halt_req = 1'b1; sch.br_taken = 1'b1; sch.br_target = 25'h10;
    #2;
    chk("halt_n_stall", 32'(sch.n_stall), 32'd0);
    chk("halt_flush",   32'(sch.flush),   32'd0);
    tick();
    sch.br_taken = 1'b1; sch.br_target = 25'h99;
    #2;
    chk("halt_state",    32'(sch.state),   32'd3);
    chk("halt_br_ign",   32'(sch.npc_enn), 32'd0);
    tick();
    sch.halt_req = 1'b1; sch.resume = 1'b1;
    tick(); #2;
    chk("halt_both_state", 32'(sch.state),   32'd3);
    chk("halt_n_stall2",   32'(sch.n_stall), 32'd0);
    sch.resume = 1'b1;
    tick(); #2;
    chk("resume_state", 32'(sch.state), 32'd2);
    chk("resume_npc",   32'(sch.npc),   32'h00F);
    chk("resume_flush", 32'(sch.flush), 32'd1);
    tick(); #2;
    chk("resume_run", 32'(sch.state),     32'd1);
    chk("cnt_at_max", 32'(sch.redir_cnt), 32'd3);

    // Halt with nothing parked resumes straight to RUN.
    sch.halt_req = 1'b1;
    tick();
    sch.resume = 1'b1;
    tick(); #2;
    chk("resume_no_pend", 32'(sch.state), 32'd1);

    // A parked branch is not replaced by a later branch, and the jump is ignored.
    sch.hz_stall = 1'b1; sch.br_taken = 1'b1; sch.br_target = 25'h300;
    tick();
    sch.hz_stall = 1'b1; sch.br_taken = 1'b1; sch.br_target = 25'h400;
    sch.jmp_valid = 1'b1; sch.jmp_target = 25'h500;
    tick(); #2;
    chk("pend_br_keep", 32'(sch.npc), 32'h2FF);
    tick();

    // A parked jump is overridden by a same-cycle branch when it is applied.
    sch.hz_stall = 1'b1; sch.jmp_valid = 1'b1; sch.jmp_target = 25'h600;
    tick();
    sch.br_taken = 1'b1; sch.br_target = 25'h700;
    #2;
    chk("pend_jmp_ovr", 32'(sch.npc), 32'h6FF);
    tick();

    // 5: a branch to target 0 wraps, and the counter stays saturated.
    sch.br_taken = 1'b1; sch.br_target = 25'h0;
    #2;
    chk("tgt0_npc", 32'(sch.npc), 32'h1FFFFFF);
    tick(); #2;
    chk("cnt_sat", 32'(sch.redir_cnt), 32'd3);

    // 6: reset while PEND discards the parked redirect.
    sch.hz_stall = 1'b1; sch.jmp_valid = 1'b1; sch.jmp_target = 25'h20;
    tick(); #2;
    chk("pre_rst_state", 32'(sch.state), 32'd2);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_n_stall", 32'(sch.n_stall), 32'd0);
    chk("rst_mid_npc_enn", 32'(sch.npc_enn), 32'd0);
    tick();
    i_rst = 1'b0;
    #2;
    chk("rst6_state",   32'(sch.state),        32'd0);
    chk("rst6_pend_v",  32'(dut.r_pend_v),     32'd0);
    chk("rst6_cnt",     32'(sch.redir_cnt),    32'd0);
    chk("rst6_n_stall", 32'(sch.n_stall),      32'd0);
    sch.boot_go = 1'b1;
    #2;
    chk("reboot_npc", 32'(sch.npc), 32'h1FFFFFF);
    tick(); #2;
    chk("reboot_no_pend", 32'(sch.npc_enn), 32'd0);
    tick(); #2;
    chk("reboot_cnt", 32'(sch.redir_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
